// File: rtl/ordenador_bolha_16bit.sv
// Bubble-sort engine: buffers N unsigned 16-bit words, sorts them ascending with one
// compare per cycle through an external <= comparator, then streams the result out.
module ordenador_bolha_16bit #(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic [15:0] cmp_a,
  output logic [15:0] cmp_b,
  input  logic        cmp_le,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic [7:0]  swap_count
);

  localparam int DATA_W = 16;
  localparam int IW     = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

  typedef enum logic [1:0] {
    LOADING,
    SORTING,
    EMITTING
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [N];
  logic [IW-1:0]     wr_idx, rd_idx, idx, pass;
  logic [IW-1:0]     idx_nx;
  logic              swapped;
  logic              accept_in, accept_out, do_swap, pass_end, sort_done;

  assign idx_nx     = idx + IW'(1);
  assign accept_in  = in_valid & in_ready;
  assign accept_out = out_valid & out_ready;
  assign do_swap    = (state == SORTING) & ~cmp_le;
  // Each pass shortens by one: the largest remaining word has bubbled to the top.
  assign pass_end   = (idx == LAST_PASS - pass);
  assign sort_done  = pass_end & (~(swapped | do_swap) | (pass == LAST_PASS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOADING;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOADING:  if (accept_in && wr_idx == LAST_IDX) state_nxt = SORTING;
      SORTING:  if (sort_done) state_nxt = EMITTING;
      EMITTING: if (accept_out && rd_idx == LAST_IDX) state_nxt = LOADING;
      default:  state_nxt = LOADING;
    endcase
  end

  // rst also gates in_ready so nothing is accepted while reset is held.
  always_comb begin
    in_ready  = (state == LOADING) & ~rst;
    busy      = (state != LOADING);
    cmp_a     = '0;
    cmp_b     = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    if (state == SORTING) begin
      cmp_a = mem[idx];
      cmp_b = mem[idx_nx];
    end
    if (state == EMITTING) begin
      out_valid = 1'b1;
      out_data  = mem[rd_idx];
      out_last  = (rd_idx == LAST_IDX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      idx        <= '0;
      pass       <= '0;
      swapped    <= 1'b0;
      swap_count <= '0;
    end else begin
      case (state)
        LOADING: if (accept_in) begin
          if (wr_idx == '0) swap_count <= '0;
          if (wr_idx == LAST_IDX) begin
            wr_idx  <= '0;
            idx     <= '0;
            pass    <= '0;
            swapped <= 1'b0;
          end else begin
            wr_idx <= wr_idx + IW'(1);
          end
        end
        SORTING: begin
          if (do_swap) swap_count <= swap_count + 8'd1;
          if (pass_end) begin
            idx     <= '0;
            swapped <= 1'b0;
            if (!sort_done) pass <= pass + IW'(1);
          end else begin
            idx     <= idx_nx;
            swapped <= swapped | do_swap;
          end
        end
        EMITTING: if (accept_out) begin
          rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Word buffer carries no reset; it is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (accept_in) mem[wr_idx] <= in_data;
    if (do_swap) begin
      mem[idx]    <= mem[idx_nx];
      mem[idx_nx] <= mem[idx];
    end
  end

endmodule
